uart_ctrl: RTL and testbench

//  Register-mapped controller that sequences one 8n1 UART PHY (tx_data/tx_valid/tx_ready,
//  rx_data/rx_ready pulse). Buffers TX bytes from the CPU bus and RX bytes from the PHY in

---
 rtl/uart_ctrl_pkg.sv | 17 +
 rtl/uart_ctrl_if.sv | 14 +
 rtl/uart_fifo.sv | 52 +++++
 rtl/uart_ctrl.sv | 146 ++++++++++++++
 tb/tb_uart_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared constants and types for the UART controller: register map, STATUS bit
// positions and the TX sequencer state encoding.
package uart_ctrl_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;

  localparam int unsigned ST_RX_NONEMPTY = 0;
  localparam int unsigned ST_TX_FULL     = 1;
  localparam int unsigned ST_TX_EMPTY    = 2;
  localparam int unsigned ST_RX_OVERRUN  = 3;
  localparam int unsigned ST_TX_IDLE     = 4;

  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_e;

endpackage

// File: rtl/uart_ctrl_if.sv
// MMIO bus between the SoC crossbar (master) and the UART controller (slave).
interface uart_ctrl_if;

  logic        req;
  logic        we;
  logic [3:0]  addr;
  logic [7:0]  wdata;
  logic [31:0] rdata;
  logic        resp_valid;

  modport master (output req, we, addr, wdata, input rdata, resp_valid);
  modport slave  (input req, we, addr, wdata, output rdata, resp_valid);

endinterface

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is accepted when a
// pop happens in the same cycle.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/uart_ctrl.sv
// Register-mapped controller for one 8n1 UART PHY with TX/RX FIFOs and overrun tracking.
// Optional interrupt output enabled by defining UART_CTRL_IRQ_EN.
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  uart_ctrl_if.slave  bus,
  output logic [7:0]  phy_tx_data_o,
  output logic        phy_tx_valid_o,
  input  logic        phy_tx_ready_i,
  input  logic [7:0]  phy_rx_data_i,
  input  logic        phy_rx_ready_i,
  output logic        irq_o
);

  tx_state_e   state_q, state_d;
  logic        tx_push, tx_pop, tx_full, tx_empty, tx_valid;
  logic        rx_pop, rx_full, rx_empty;
  logic [7:0]  tx_dout, rx_dout;
  logic        overrun_q, overrun_d, ovr_clr, ovr_set;
  logic        rd_req, rd_data;
  logic [4:0]  status;
  logic [31:0] rdata_q, rdata_d;
  logic        resp_valid_q;

  assign rd_req  = bus.req & ~bus.we;
  assign rd_data = rd_req & (bus.addr == ADDR_DATA);
  assign tx_push = bus.req & bus.we & (bus.addr == ADDR_DATA);
  assign ovr_clr = bus.req & bus.we & (bus.addr == ADDR_STATUS) & bus.wdata[ST_RX_OVERRUN];
  assign rx_pop  = rd_data & ~rx_empty;

  uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .din_i   (bus.wdata),
    .dout_o  (tx_dout),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (phy_rx_ready_i),
    .pop_i   (rx_pop),
    .din_i   (phy_rx_data_i),
    .dout_o  (rx_dout),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  // A same-cycle bus pop frees a slot, so the incoming byte is not an overrun.
  assign ovr_set   = phy_rx_ready_i & rx_full & ~rx_pop;
  assign overrun_d = ovr_set | (overrun_q & ~ovr_clr);

  always_comb begin
    state_d  = state_q;
    tx_valid = 1'b0;
    tx_pop   = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        tx_valid = ~tx_empty;
        if (~tx_empty & phy_tx_ready_i) begin
          tx_pop  = 1'b1;
          state_d = TX_BUSY;
        end
      end
      TX_BUSY: if (phy_tx_ready_i) state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase
  end

  assign phy_tx_valid_o = tx_valid;
  assign phy_tx_data_o  = tx_dout;

  always_comb begin
    status                 = '0;
    status[ST_RX_NONEMPTY] = ~rx_empty;
    status[ST_TX_FULL]     = tx_full;
    status[ST_TX_EMPTY]    = tx_empty;
    status[ST_RX_OVERRUN]  = overrun_q;
    status[ST_TX_IDLE]     = tx_empty & (state_q == TX_IDLE) & phy_tx_ready_i;
  end

`ifdef UART_CTRL_IRQ_EN
  logic rx_irq_en_q, tx_irq_en_q, irq_q, irq_d;

  assign irq_d = (rx_irq_en_q & ~rx_empty) | (tx_irq_en_q & tx_empty) | overrun_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_irq_en_q <= 1'b0;
      tx_irq_en_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      irq_q <= irq_d;
      if (bus.req & bus.we & (bus.addr == ADDR_CTRL)) begin
        rx_irq_en_q <= bus.wdata[0];
        tx_irq_en_q <= bus.wdata[1];
      end
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    rdata_d = '0;
    if (rd_req) begin
      case (bus.addr)
        ADDR_DATA:   rdata_d[7:0] = rx_empty ? 8'h00 : rx_dout;
        ADDR_STATUS: rdata_d[4:0] = status;
`ifdef UART_CTRL_IRQ_EN
        ADDR_CTRL:   rdata_d[1:0] = {tx_irq_en_q, rx_irq_en_q};
`endif
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= TX_IDLE;
      overrun_q    <= 1'b0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      overrun_q    <= overrun_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= bus.req;
    end
  end

  assign bus.rdata      = rdata_q;
  assign bus.resp_valid = resp_valid_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl: register-map vector table plus TX/RX/overrun/reset/IRQ
// sequences against a simple PHY model.
module tb_uart_ctrl;
  import uart_ctrl_pkg::*;

  typedef struct {
    logic [3:0]  addr;
    logic        we;
    logic [7:0]  wdata;
    logic [31:0] exp;
  } vec_t;

`ifdef UART_CTRL_IRQ_EN
  localparam logic [31:0] CTRL_RB = 32'h3;
`else
  localparam logic [31:0] CTRL_RB = 32'h0;
`endif

  logic       clk, rst;
  logic [7:0] phy_tx_data, phy_rx_data;
  logic       phy_tx_valid, phy_tx_ready, phy_rx_ready, irq;
  logic       tx_hold;
  int         busy_cnt;
  logic [7:0] tx_seen[$];
  int         checks, errors;

  uart_ctrl_if bus_if ();

  uart_ctrl #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus_if),
    .phy_tx_data_o  (phy_tx_data),
    .phy_tx_valid_o (phy_tx_valid),
    .phy_tx_ready_i (phy_tx_ready),
    .phy_rx_data_i  (phy_rx_data),
    .phy_rx_ready_i (phy_rx_ready),
    .irq_o          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PHY model: busy for 3 cycles after each accepted byte; tx_hold forces not-ready.
  assign phy_tx_ready = !tx_hold && (busy_cnt == 0);
  always @(posedge clk) begin
    if (rst) busy_cnt <= 0;
    else if (phy_tx_valid && phy_tx_ready) begin
      tx_seen.push_back(phy_tx_data);
      busy_cnt <= 3;
    end else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_op(input logic [3:0] a, input logic w, input logic [7:0] d,
                        input logic rx_en, input logic [7:0] rx_byte,
                        output logic [31:0] rd, output logic rv);
    @(negedge clk);
    bus_if.req = 1'b1; bus_if.we = w; bus_if.addr = a; bus_if.wdata = d;
    phy_rx_ready = rx_en; phy_rx_data = rx_byte;
    @(negedge clk);
    bus_if.req = 1'b0; bus_if.we = 1'b0; phy_rx_ready = 1'b0;
    rd = bus_if.rdata;
    rv = bus_if.resp_valid;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic        rv;
    bus_op(a, 1'b0, 8'h00, 1'b0, 8'h00, rd, rv);
    check({name, "_resp"}, {31'b0, rv}, 32'h1);
    check(name, rd, exp);
  endtask

  task automatic wr(input string name, input logic [3:0] a, input logic [7:0] d);
    logic [31:0] rd;
    logic        rv;
    bus_op(a, 1'b1, d, 1'b0, 8'h00, rd, rv);
    check({name, "_resp"}, {31'b0, rv}, 32'h1);
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(negedge clk);
    phy_rx_ready = 1'b1; phy_rx_data = b;
    @(negedge clk);
    phy_rx_ready = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k;
    k = 0;
    while (tx_seen.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("tx_wait_count", tx_seen.size(), n);
  endtask

  vec_t        vecs[$];
  logic [31:0] rd;
  logic        rv;
  int          n_before;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    bus_if.req = 0; bus_if.we = 0; bus_if.addr = 0; bus_if.wdata = 0;
    phy_rx_ready = 0; phy_rx_data = 0; tx_hold = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    check("rst_rdata", bus_if.rdata, 32'h0);
    check("rst_resp_valid", {31'b0, bus_if.resp_valid}, 32'h0);
    check("rst_tx_valid", {31'b0, phy_tx_valid}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rst = 0;

    // Register map table
    vecs.push_back('{ADDR_STATUS, 1'b0, 8'h00, 32'h14});
    vecs.push_back('{ADDR_DATA,   1'b0, 8'h00, 32'h0});
    vecs.push_back('{ADDR_CTRL,   1'b0, 8'h00, 32'h0});
    vecs.push_back('{4'hC,        1'b0, 8'h00, 32'h0});
    vecs.push_back('{4'hC,        1'b1, 8'hFF, 32'h0});
    vecs.push_back('{4'hC,        1'b0, 8'h00, 32'h0});
    vecs.push_back('{ADDR_CTRL,   1'b1, 8'h03, 32'h0});
    vecs.push_back('{ADDR_CTRL,   1'b0, 8'h00, CTRL_RB});
    vecs.push_back('{ADDR_CTRL,   1'b1, 8'h00, 32'h0});
    vecs.push_back('{ADDR_CTRL,   1'b0, 8'h00, 32'h0});
    vecs.push_back('{4'h1,        1'b0, 8'h00, 32'h0});
    vecs.push_back('{ADDR_STATUS, 1'b1, 8'hF7, 32'h0});
    vecs.push_back('{ADDR_STATUS, 1'b0, 8'h00, 32'h14});
    foreach (vecs[i]) begin
      bus_op(vecs[i].addr, vecs[i].we, vecs[i].wdata, 1'b0, 8'h00, rd, rv);
      check($sformatf("vec%0d_resp", i), {31'b0, rv}, 32'h1);
      if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
    end
    @(negedge clk);
    check("resp_one_cycle", {31'b0, bus_if.resp_valid}, 32'h0);

    // Two TX bytes in order
    wr("tx_wr41", ADDR_DATA, 8'h41);
    wr("tx_wr42", ADDR_DATA, 8'h42);
    wait_tx(2, 50);
    if (tx_seen.size() == 2) begin
      check("tx_byte0", {24'b0, tx_seen[0]}, 32'h41);
      check("tx_byte1", {24'b0, tx_seen[1]}, 32'h42);
    end
    repeat (10) @(negedge clk);
    rd_chk("tx_idle_after", ADDR_STATUS, 32'h14);

    // Overfill TX with PHY held not-ready
    tx_hold = 1;
    tx_seen.delete();
    for (int i = 0; i < 17; i++) wr($sformatf("txf_wr%0d", i), ADDR_DATA, 8'(8'h60 + i));
    rd_chk("tx_full_status", ADDR_STATUS, 32'h02);
    check("tx_valid_held", {31'b0, phy_tx_valid}, 32'h1);
    check("tx_none_while_held", tx_seen.size(), 0);
    tx_hold = 0;
    wait_tx(16, 400);
    repeat (30) @(negedge clk);
    check("tx_exactly16", tx_seen.size(), 16);
    for (int i = 0; i < 16 && i < tx_seen.size(); i++)
      check($sformatf("txf_byte%0d", i), {24'b0, tx_seen[i]}, 32'(8'h60 + i));
    rd_chk("tx_drained_status", ADDR_STATUS, 32'h14);

    // Single RX byte
    rx_pulse(8'h55);
    rd_chk("rx_status_ne", ADDR_STATUS, 32'h15);
    rd_chk("rx_data55", ADDR_DATA, 32'h55);
    rd_chk("rx_status_empty", ADDR_STATUS, 32'h14);
    rd_chk("rx_empty_read", ADDR_DATA, 32'h0);

    // RX overrun, clear, set-beats-clear, full read+push
    for (int i = 0; i < 17; i++) rx_pulse(8'(8'h80 + i));
    rd_chk("ovr_status", ADDR_STATUS, 32'h1D);
    wr("ovr_clr", ADDR_STATUS, 8'h08);
    rd_chk("ovr_cleared", ADDR_STATUS, 32'h15);
    bus_op(ADDR_STATUS, 1'b1, 8'h08, 1'b1, 8'h99, rd, rv);
    rd_chk("ovr_set_wins", ADDR_STATUS, 32'h1D);
    wr("ovr_clr2", ADDR_STATUS, 8'h08);
    bus_op(ADDR_DATA, 1'b0, 8'h00, 1'b1, 8'hAA, rd, rv);
    check("full_rdpush_data", rd, 32'h80);
    rd_chk("full_rdpush_noovr", ADDR_STATUS, 32'h15);
    for (int i = 1; i < 16; i++) rd_chk($sformatf("rx_keep%0d", i), ADDR_DATA, 32'(8'h80 + i));
    rd_chk("rx_tail_aa", ADDR_DATA, 32'hAA);
    rd_chk("rx_drained", ADDR_DATA, 32'h0);

    // Reset with TX traffic in flight
    tx_seen.delete();
    wr("rst_wr0", ADDR_DATA, 8'h11);
    wr("rst_wr1", ADDR_DATA, 8'h22);
    wr("rst_wr2", ADDR_DATA, 8'h33);
    rst = 1;
    n_before = tx_seen.size();
    @(negedge clk);
    check("rst_mid_tx_valid", {31'b0, phy_tx_valid}, 32'h0);
    rst = 0;
    rd_chk("rst_mid_status", ADDR_STATUS, 32'h14);
    repeat (20) @(negedge clk);
    check("rst_mid_no_more_tx", tx_seen.size(), n_before);

    // Interrupt
`ifdef UART_CTRL_IRQ_EN
    wr("irq_ctrl", ADDR_CTRL, 8'h01);
    rx_pulse(8'h33);
    check("irq_not_yet", {31'b0, irq}, 32'h0);
    @(negedge clk);
    check("irq_set", {31'b0, irq}, 32'h1);
    rd_chk("irq_data", ADDR_DATA, 32'h33);
    check("irq_hold", {31'b0, irq}, 32'h1);
    @(negedge clk);
    check("irq_clear", {31'b0, irq}, 32'h0);
`else
    rx_pulse(8'h33);
    @(negedge clk);
    check("irq_tied0", {31'b0, irq}, 32'h0);
    rd_chk("irq_data", ADDR_DATA, 32'h33);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
